gpr_wb: RTL and testbench
=========================

GPR_WB -- requirements
Module: gpr_wb

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: width of the commit counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port RegWrite, input, 1 bit: write request for the current write-back value.
REQ-005 The block SHALL have port WrAddr, input, 5 bits: destination register number.
REQ-006 The block SHALL have port WrReg, input, 32 bits: write-back data from the upstream GPR select mux.
REQ-007 The block SHALL have port stall, input, 1 bit: blocks capture of a new write.
REQ-008 The block SHALL have port flush, input, 1 bit: discards the pending write.
REQ-009 The block SHALL have ports RsAddr and RtAddr, input, 5 bits each: read addresses.
REQ-010 The block SHALL have ports RsData and RtData, output, 32 bits each: read data (combinational).
REQ-011 The block SHALL have port pend_valid, output, 1 bit: pending-write latch is occupied.
REQ-012 The block SHALL have port commit_cnt, output, CNT_W bits: number of committed writes to registers 1..31.

Function
REQ-013 The block SHALL hold 32 x 32-bit registers; register 0 SHALL always read 0 and SHALL never be written.
REQ-014 Capture: on a rising edge with RegWrite=1, stall=0 and flush=0, the pending latch SHALL load {WrAddr, WrReg}, and pend_valid SHALL be 1 after the edge.
REQ-015 Commit: on every rising edge with pend_valid=1 and flush=0, the pending data SHALL be written to the array at the pending address; write-back latency from capture to the array SHALL be exactly 1 cycle.
REQ-016 A commit and a new capture on the same edge SHALL both occur, and pend_valid SHALL stay 1.
REQ-017 A commit with no capture on the same edge SHALL clear pend_valid.
REQ-018 stall=1 SHALL block capture only; an existing pending write SHALL still commit.
REQ-019 flush=1 SHALL clear pend_valid without writing the array and SHALL block capture on that edge; flush SHALL take priority over stall and RegWrite.
REQ-020 A capture with WrAddr=0 SHALL be accepted into the latch; its commit SHALL leave the array unchanged and SHALL NOT increment commit_cnt.
REQ-021 Read ports: address 0 SHALL return 0; otherwise, when pend_valid=1 and the pending address matches, the port SHALL return the pending data; otherwise it SHALL return the array content.
REQ-022 commit_cnt SHALL increment by 1 on each commit to a nonzero address, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 Both read ports SHALL be independent; equal RsAddr and RtAddr SHALL return identical data.

Reset
REQ-024 rst_n=0 SHALL asynchronously clear all 32 registers, the pending latch (address and data), pend_valid and commit_cnt to 0.
REQ-025 A write pending at reset assertion SHALL be lost and SHALL NOT commit after release.
REQ-026 The first capture SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-027 With macro GPR_SAME_CYCLE_BYPASS_EN defined, a read port whose nonzero address equals WrAddr while RegWrite=1, stall=0 and flush=0 SHALL return WrReg in the same cycle; this path SHALL take priority over the pending and array values.
REQ-028 Without GPR_SAME_CYCLE_BYPASS_EN, REQ-021 alone SHALL define read data, and the new value SHALL become visible only after the capture edge.

Verification
REQ-029 The bench SHALL cover reset then read: rst_n=0 then 1, read registers 1..31 -> all return 0, pend_valid=0, commit_cnt=0.
REQ-030 The bench SHALL cover write then forward: RegWrite=1, WrAddr=5, WrReg=32'hDEADBEEF for one edge, RsAddr=5 -> RsData=DEADBEEF after the edge (from pending); one edge later the array holds DEADBEEF, pend_valid=0 and commit_cnt=1.
REQ-031 The bench SHALL cover back-to-back writes: WrAddr=3 with data 0x11, then WrAddr=3 with data 0x22 on consecutive edges -> pend_valid stays 1, the read returns 0x11 then 0x22, and commit_cnt=2.
REQ-032 The bench SHALL cover flush: capture WrAddr=7 with data 0x55, then assert flush on the next edge -> pend_valid=0, register 7 reads 0, and commit_cnt is unchanged.
REQ-033 The bench SHALL cover register 0: write WrAddr=0 with data 0xFFFFFFFF -> register 0 reads 0 and commit_cnt is not incremented.
REQ-034 The bench SHALL cover the bypass: with GPR_SAME_CYCLE_BYPASS_EN defined, drive RegWrite=1, WrAddr=9, WrReg=0x1234 and RtAddr=9 before the edge -> RtData=0x1234 in the same cycle; without the macro -> RtData=0 until after the edge.

Source files
------------

// File: rtl/gpr_wb.sv
// -----------------------------------------------------------------------------
// gpr_wb -- 32 x 32-bit general-purpose register file with a one-entry
// write-back pending latch.
//
// A write request is first captured into the pending latch and committed to
// the register array on the following rising edge. Reads forward the pending
// value when its address matches, so a captured write is visible immediately
// after the capture edge. Register 0 always reads zero and is never written.
//
// Optional build macro:
//   GPR_SAME_CYCLE_BYPASS_EN -- when defined, a read whose nonzero address
//   matches an incoming, accepted write returns WrReg combinationally in the
//   same cycle (highest read priority).
//
// Parameters:
//   CNT_W       width of the commit counter (default 32)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   RegWrite    write request for the current write-back value
//   WrAddr      destination register number
//   WrReg       write-back data
//   stall       blocks capture of a new write (pending write still commits)
//   flush       discards the pending write and blocks capture
//   RsAddr      read address, port s
//   RtAddr      read address, port t
//   RsData      read data, port s (combinational)
//   RtData      read data, port t (combinational)
//   pend_valid  pending-write latch is occupied
//   commit_cnt  number of committed writes to registers 1..31 (wraps)
// -----------------------------------------------------------------------------
module gpr_wb #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             RegWrite,
   input  logic [4:0]       WrAddr,
   input  logic [31:0]      WrReg,
   input  logic             stall,
   input  logic             flush,
   input  logic [4:0]       RsAddr,
   input  logic [4:0]       RtAddr,
   output logic [31:0]      RsData,
   output logic [31:0]      RtData,
   output logic             pend_valid,
   output logic [CNT_W-1:0] commit_cnt
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]      regs_q [32];
   logic [31:0]      regs_d [32];
   logic             pend_valid_q, pend_valid_d;
   logic [4:0]       pend_addr_q,  pend_addr_d;
   logic [31:0]      pend_data_q,  pend_data_d;
   logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;

   logic capture;
   logic commit;
   logic commit_nz;

   // flush wins over both stall and RegWrite.
   assign capture   = RegWrite && !stall && !flush;
   assign commit    = pend_valid_q && !flush;
   assign commit_nz = commit && (pend_addr_q != 5'd0);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default at the top of the block so that no path
   // leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      regs_d       = regs_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      commit_cnt_d = commit_cnt_q;

      // The latch is occupied after an edge exactly when that edge captured:
      // a commit without capture empties it, and flush empties it and blocks
      // capture.
      pend_valid_d = capture;

      if (capture) begin
         pend_addr_d = WrAddr;
         pend_data_d = WrReg;
      end

      // A commit to register 0 is accepted but has no architectural effect.
      if (commit_nz) begin
         regs_d[pend_addr_q] = pend_data_q;
         commit_cnt_d        = commit_cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: non-blocking assignments in clocked blocks so every flop samples its
   // pre-edge value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         commit_cnt_q <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   // NOTE: the register array is flops, not a RAM macro, because reset must
   // clear every entry asynchronously; a resettable array cannot map to SRAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports
   // ---------------------------------------------------------------------------
   logic [4:0]  rd_addr [2];
   logic [31:0] rd_data [2];

   assign rd_addr[0] = RsAddr;
   assign rd_addr[1] = RtAddr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = regs_q[rd_addr[p]];
         if (pend_valid_q && (pend_addr_q == rd_addr[p])) begin
            rd_data[p] = pend_data_q;
         end
`ifdef GPR_SAME_CYCLE_BYPASS_EN
         // Incoming write overrides both pending and array contents.
         if (capture && (WrAddr == rd_addr[p])) begin
            rd_data[p] = WrReg;
         end
`endif
         // Register 0 reads zero even if a zero-address write is pending.
         if (rd_addr[p] == 5'd0) begin
            rd_data[p] = '0;
         end
      end
   end

   assign RsData     = rd_data[0];
   assign RtData     = rd_data[1];
   assign pend_valid = pend_valid_q;
   assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_gpr_wb.sv
// -----------------------------------------------------------------------------
// tb_gpr_wb -- directed self-checking bench for gpr_wb.
// A small commit counter width is used so the wrap-around can be reached.
// -----------------------------------------------------------------------------
module tb_gpr_wb;

   localparam int CNT_W = 3;

   logic             clk;
   logic             rst_n;
   logic             RegWrite;
   logic [4:0]       WrAddr;
   logic [31:0]      WrReg;
   logic             stall;
   logic             flush;
   logic [4:0]       RsAddr;
   logic [4:0]       RtAddr;
   logic [31:0]      RsData;
   logic [31:0]      RtData;
   logic             pend_valid;
   logic [CNT_W-1:0] commit_cnt;

   int total = 0;
   int bad   = 0;

   gpr_wb #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RegWrite   (RegWrite),
      .WrAddr     (WrAddr),
      .WrReg      (WrReg),
      .stall      (stall),
      .flush      (flush),
      .RsAddr     (RsAddr),
      .RtAddr     (RtAddr),
      .RsData     (RsData),
      .RtData     (RtData),
      .pend_valid (pend_valid),
      .commit_cnt (commit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int exp);
      check(tag, 32'(commit_cnt), 32'(exp[CNT_W-1:0]));
   endtask

   logic [31:0] exp_bypass;
   logic        all_zero;

   initial begin
      rst_n    = 1'b0;
      RegWrite = 1'b0;
      WrAddr   = '0;
      WrReg    = '0;
      stall    = 1'b0;
      flush    = 1'b0;
      RsAddr   = '0;
      RtAddr   = '0;

      // ---- reset then read ----------------------------------------------
      step();
      step();
      check("rst_pend_valid", 32'(pend_valid), 32'd0);
      chk_cnt("rst_commit_cnt", 0);
      rst_n = 1'b1;
      all_zero = 1'b1;
      for (int a = 1; a < 32; a++) begin
         RsAddr = 5'(a);
         RtAddr = 5'(31 - a + 1);
         #1;
         if (RsData !== 32'd0 || RtData !== 32'd0) all_zero = 1'b0;
      end
      check("rst_all_regs_zero", 32'(all_zero), 32'd1);

      // ---- write then forward -------------------------------------------
      RegWrite = 1'b1; WrAddr = 5'd5; WrReg = 32'hDEADBEEF; RsAddr = 5'd5;
      step();
      RegWrite = 1'b0;
      check("wr5_pend_valid", 32'(pend_valid), 32'd1);
      check("wr5_fwd", RsData, 32'hDEADBEEF);
      chk_cnt("wr5_cnt_before_commit", 0);
      step();
      check("wr5_commit_pv", 32'(pend_valid), 32'd0);
      check("wr5_array", RsData, 32'hDEADBEEF);
      chk_cnt("wr5_cnt", 1);

      // ---- back-to-back writes to the same register ---------------------
      RegWrite = 1'b1; WrAddr = 5'd3; WrReg = 32'h11; RsAddr = 5'd3;
      step();
      check("b2b_pv1", 32'(pend_valid), 32'd1);
      check("b2b_rd1", RsData, 32'h11);
      WrReg = 32'h22;
      step();
      RegWrite = 1'b0;
      check("b2b_pv2", 32'(pend_valid), 32'd1);
      check("b2b_rd2", RsData, 32'h22);
      chk_cnt("b2b_cnt_mid", 2);
      step();
      check("b2b_pv3", 32'(pend_valid), 32'd0);
      check("b2b_rd3", RsData, 32'h22);
      chk_cnt("b2b_cnt", 3);

      // ---- flush discards pending write ---------------------------------
      RegWrite = 1'b1; WrAddr = 5'd7; WrReg = 32'h55; RsAddr = 5'd7;
      step();
      check("fl_pv_before", 32'(pend_valid), 32'd1);
      RegWrite = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_pv", 32'(pend_valid), 32'd0);
      check("fl_r7", RsData, 32'd0);
      chk_cnt("fl_cnt", 3);

      // ---- register 0 ---------------------------------------------------
      RegWrite = 1'b1; WrAddr = 5'd0; WrReg = 32'hFFFFFFFF; RsAddr = 5'd0; RtAddr = 5'd0;
      #1;
      check("r0_same_cycle", RsData, 32'd0);
      step();
      RegWrite = 1'b0;
      check("r0_pv", 32'(pend_valid), 32'd1);
      check("r0_fwd", RtData, 32'd0);
      step();
      check("r0_rd", RsData, 32'd0);
      chk_cnt("r0_cnt", 3);

      // ---- stall blocks capture only -------------------------------------
      RegWrite = 1'b1; WrAddr = 5'd10; WrReg = 32'hA0A0A0A0;
      step();
      stall = 1'b1; WrAddr = 5'd11; WrReg = 32'hB0B0B0B0;
      RsAddr = 5'd10; RtAddr = 5'd11;
      step();
      stall = 1'b0; RegWrite = 1'b0;
      check("st_pv", 32'(pend_valid), 32'd0);
      check("st_r10", RsData, 32'hA0A0A0A0);
      check("st_r11", RtData, 32'd0);
      chk_cnt("st_cnt", 4);

      // ---- flush has priority over RegWrite and stall -------------------
      RegWrite = 1'b1; stall = 1'b1; flush = 1'b1; WrAddr = 5'd12; WrReg = 32'hC0C0;
      RsAddr = 5'd12;
      step();
      RegWrite = 1'b0; stall = 1'b0; flush = 1'b0;
      check("flp_pv", 32'(pend_valid), 32'd0);
      check("flp_r12", RsData, 32'd0);

      // ---- same-cycle bypass (or its absence) ---------------------------
`ifdef GPR_SAME_CYCLE_BYPASS_EN
      exp_bypass = 32'h1234;
`else
      exp_bypass = 32'h0;
`endif
      RegWrite = 1'b1; WrAddr = 5'd9; WrReg = 32'h1234; RtAddr = 5'd9; RsAddr = 5'd9;
      #1;
      check("byp_same_cycle", RtData, exp_bypass);
      step();
      RegWrite = 1'b0;
      check("byp_after_edge", RtData, 32'h1234);
      check("byp_rs_eq_rt", RsData, 32'h1234);
      step();
      chk_cnt("byp_cnt", 5);

      // ---- commit counter wrap ------------------------------------------
      RegWrite = 1'b1; WrAddr = 5'd20; WrReg = 32'h20;
      step();
      WrAddr = 5'd21; WrReg = 32'h21;
      step();
      WrAddr = 5'd22; WrReg = 32'h22;
      step();
      RegWrite = 1'b0;
      chk_cnt("wrap_cnt_7", 7);
      step();
      chk_cnt("wrap_cnt_0", 8);
      RsAddr = 5'd20; RtAddr = 5'd22;
      #1;
      check("wrap_r20", RsData, 32'h20);
      check("wrap_r22", RtData, 32'h22);

      // ---- reset with a pending write -----------------------------------
      RegWrite = 1'b1; WrAddr = 5'd13; WrReg = 32'h77;
      step();
      RegWrite = 1'b0;
      check("rp_pv", 32'(pend_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      RsAddr = 5'd5; RtAddr = 5'd13;
      #1;
      check("rp_async_pv", 32'(pend_valid), 32'd0);
      chk_cnt("rp_async_cnt", 0);
      check("rp_async_r5", RsData, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      check("rp_lost_r13", RtData, 32'd0);
      check("rp_lost_pv", 32'(pend_valid), 32'd0);
      chk_cnt("rp_lost_cnt", 0);

      // First capture on the first edge after release.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      RegWrite = 1'b1; WrAddr = 5'd14; WrReg = 32'h1414; RsAddr = 5'd14;
      step();
      RegWrite = 1'b0;
      check("first_cap_pv", 32'(pend_valid), 32'd1);
      check("first_cap_rd", RsData, 32'h1414);
      step();
      chk_cnt("first_cap_cnt", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
